// File: rtl/press_fsm_pkg.sv
// Shared state encoding and parameter legality helpers for press_classifier.
package press_fsm_pkg;

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StPressed    = 3'd1,
        StLongHeld   = 3'd2,
        StWaitGap    = 3'd3,
        StSecondHeld = 3'd4,
        StInvalid    = 3'd7
    } press_state_e;

    function automatic bit ticks_legal(input int unsigned ticks);
        return ticks >= 1;
    endfunction

    function automatic bit width_legal(input int unsigned width);
        return width >= 1;
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers a synchronous level and derives rise/fall strobes, both as
// same-cycle combinational terms and as registered one-cycle pulses.
module edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o,
    output logic rise_pulse_o,
    output logic fall_pulse_o
);

    logic sig_q;
    logic rise_q;
    logic fall_q;

    assign rise_o       = sig_i & ~sig_q;
    assign fall_o       = ~sig_i & sig_q;
    assign rise_pulse_o = rise_q;
    assign fall_pulse_o = fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            rise_q <= rise_o;
            fall_q <= fall_o;
        end
    end

endmodule

// File: rtl/press_classifier.sv
// Times each debounced press in m_tick units and classifies it as short, long or double.
// Double-press detection is built only when PRESS_CLASSIFIER_DOUBLE_PRESS_EN is defined.
module press_classifier
    import press_fsm_pkg::*;
#(
    parameter int unsigned LONG_TICKS  = 20,
    parameter int unsigned GAP_TICKS   = 8,
    parameter int unsigned PRESS_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   db_i,
    input  logic                   m_tick_i,
    output logic                   rise_o,
    output logic                   fall_o,
    output logic                   short_press_o,
    output logic                   long_press_o,
    output logic                   double_press_o,
    output logic                   busy_o,
    output logic [PRESS_CNT_W-1:0] press_cnt_o
);

    if (!ticks_legal(LONG_TICKS)) begin : g_long_chk
        $error("press_classifier: LONG_TICKS must be >= 1");
    end
    if (!ticks_legal(GAP_TICKS)) begin : g_gap_chk
        $error("press_classifier: GAP_TICKS must be >= 1");
    end
    if (!width_legal(PRESS_CNT_W)) begin : g_cnt_chk
        $error("press_classifier: PRESS_CNT_W must be >= 1");
    end

    localparam int unsigned DurW = cnt_width(LONG_TICKS);

    logic rise;
    logic fall;

    edge_detect u_edge_detect (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sig_i       (db_i),
        .rise_o      (rise),
        .fall_o      (fall),
        .rise_pulse_o(rise_o),
        .fall_pulse_o(fall_o)
    );

    press_state_e            state_q, state_d;
    logic [DurW-1:0]         dur_q, dur_d;
    logic                    short_q, short_d;
    logic                    long_q, long_d;
    logic                    double_d;
    logic                    busy_q;
    logic [PRESS_CNT_W-1:0]  press_cnt_q;

`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    localparam int unsigned GapW = cnt_width(GAP_TICKS);
    logic [GapW-1:0] gap_q, gap_d;
    logic            double_q;
`endif

    always_comb begin
        state_d  = StInvalid;
        dur_d    = rise ? '0 : dur_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
        gap_d    = gap_q;
`endif
        unique case (state_q)
            StIdle: begin
                state_d = rise ? StPressed : StIdle;
            end
            StPressed: begin
                // A release beats a coincident threshold tick: the press stays short.
                if (fall) begin
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
                    state_d = StWaitGap;
                    gap_d   = '0;
`else
                    state_d = StIdle;
                    short_d = 1'b1;
`endif
                end else if (m_tick_i && (dur_q == DurW'(LONG_TICKS - 1))) begin
                    state_d = StLongHeld;
                    long_d  = 1'b1;
                end else begin
                    state_d = StPressed;
                    if (m_tick_i) begin
                        dur_d = dur_q + DurW'(1);
                    end
                end
            end
            StLongHeld: begin
                state_d = fall ? StIdle : StLongHeld;
            end
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
            StWaitGap: begin
                if (rise) begin
                    state_d  = StSecondHeld;
                    double_d = 1'b1;
                end else if (m_tick_i && (gap_q == GapW'(GAP_TICKS - 1))) begin
                    state_d = StIdle;
                    short_d = 1'b1;
                end else begin
                    state_d = StWaitGap;
                    if (m_tick_i) begin
                        gap_d = gap_q + GapW'(1);
                    end
                end
            end
            StSecondHeld: begin
                state_d = fall ? StIdle : StSecondHeld;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            dur_q       <= '0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            busy_q      <= 1'b0;
            press_cnt_q <= '0;
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
            gap_q       <= '0;
            double_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            short_q <= short_d;
            long_q  <= long_d;
            busy_q  <= (state_d != StIdle);
            if (rise) begin
                press_cnt_q <= press_cnt_q + PRESS_CNT_W'(1);
            end
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
            gap_q    <= gap_d;
            double_q <= double_d;
`endif
        end
    end

    assign short_press_o = short_q;
    assign long_press_o  = long_q;
    assign busy_o        = busy_q;
    assign press_cnt_o   = press_cnt_q;

`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    assign double_press_o = double_q;
`else
    assign double_press_o = 1'b0;
    logic unused_double;
    assign unused_double = double_d;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier: a press-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_press_classifier;

    localparam int unsigned LT = 4;
    localparam int unsigned GT = 3;
    localparam int unsigned CW = 2;
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
    localparam bit DP = 1'b1;
`else
    localparam bit DP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          db;
    logic          mt;
    logic          rise_o, fall_o, short_o, long_o, double_o, busy_o;
    logic [CW-1:0] cnt_o;

    press_classifier #(
        .LONG_TICKS (LT),
        .GAP_TICKS  (GT),
        .PRESS_CNT_W(CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .db_i          (db),
        .m_tick_i      (mt),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .short_press_o (short_o),
        .long_press_o  (long_o),
        .double_press_o(double_o),
        .busy_o        (busy_o),
        .press_cnt_o   (cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkc(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: reasons about presses, hold ticks and gap ticks directly.
    int  prev_db, held, gap_el, cnt;
    bit  holding, classified, waiting;
    logic e_rise, e_fall, e_short, e_long, e_double, e_busy;
    logic [CW-1:0] e_cnt;

    always @(posedge clk) begin
        bit r, f;
        e_rise = 0; e_fall = 0; e_short = 0; e_long = 0; e_double = 0;
        if (rst) begin
            prev_db = 0; held = 0; gap_el = 0; cnt = 0;
            holding = 0; classified = 0; waiting = 0;
        end else begin
            r = db && (prev_db == 0);
            f = !db && (prev_db == 1);
            prev_db = db ? 1 : 0;
            if (r) cnt = (cnt + 1) % (1 << CW);
            e_rise = r;
            e_fall = f;
            if (waiting) begin
                if (r) begin
                    e_double = 1; waiting = 0; holding = 1; classified = 1;
                end else if (mt) begin
                    gap_el++;
                    if (gap_el == GT) begin e_short = 1; waiting = 0; end
                end
            end else if (holding) begin
                if (f) begin
                    holding = 0;
                    if (!classified) begin
                        if (DP) begin waiting = 1; gap_el = 0; end
                        else e_short = 1;
                    end
                end else if (mt && !classified) begin
                    held++;
                    if (held == LT) begin e_long = 1; classified = 1; end
                end
            end else if (r) begin
                holding = 1; classified = 0; held = 0;
            end
        end
        e_busy = holding || waiting;
        e_cnt  = cnt[CW-1:0];
    end

    always @(negedge clk) begin
        if (started) begin
            check1("model rise_o", rise_o, e_rise);
            check1("model fall_o", fall_o, e_fall);
            check1("model short_press_o", short_o, e_short);
            check1("model long_press_o", long_o, e_long);
            check1("model double_press_o", double_o, e_double);
            check1("model busy_o", busy_o, e_busy);
            checkc("model press_cnt_o", cnt_o, e_cnt);
        end
    end

    task automatic cyc(input logic d, input logic t);
        db = d;
        mt = t;
        @(negedge clk);
    endtask

    task automatic settle();
        for (int i = 0; i < GT; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; db = 1'b0; mt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        started = 1'b1;
        check1("reset busy", busy_o, 1'b0);
        check1("reset short", short_o, 1'b0);
        checkc("reset cnt", cnt_o, 2'd0);
        rst = 1'b0;

        // Short press: two ticks held.
        cyc(1, 0);
        check1("short rise", rise_o, 1'b1);
        check1("short busy", busy_o, 1'b1);
        checkc("short cnt", cnt_o, 2'd1);
        cyc(1, 1); cyc(1, 1);
        cyc(0, 0);
        check1("short fall", fall_o, 1'b1);
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
        check1("short deferred", short_o, 1'b0);
        cyc(0, 1); cyc(0, 1); cyc(0, 1);
        check1("gap expiry short", short_o, 1'b1);
`else
        check1("short pulse", short_o, 1'b1);
`endif
        cyc(0, 0);
        check1("short idle busy", busy_o, 1'b0);

        // Long press: six ticks held.
        cyc(1, 0);
        cyc(1, 1); cyc(1, 1); cyc(1, 1);
        cyc(1, 1);
        check1("long pulse", long_o, 1'b1);
        cyc(1, 1);
        check1("long single pulse", long_o, 1'b0);
        cyc(1, 1);
        cyc(0, 0);
        check1("long release fall", fall_o, 1'b1);
        check1("long release no short", short_o, 1'b0);
        cyc(0, 0);
        check1("long busy low", busy_o, 1'b0);
        checkc("long cnt", cnt_o, 2'd2);

        // Release coincident with the threshold tick.
        cyc(1, 0);
        cyc(1, 1); cyc(1, 1); cyc(1, 1);
        cyc(0, 1);
        check1("tie no long", long_o, 1'b0);
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
        cyc(0, 1); cyc(0, 1); cyc(0, 1);
        check1("tie short after gap", short_o, 1'b1);
`else
        check1("tie short", short_o, 1'b1);
`endif
        cyc(0, 0);

        // Second press one tick after release.
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 1);
        cyc(1, 0);
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
        check1("double pulse", double_o, 1'b1);
        check1("double no short", short_o, 1'b0);
`else
        check1("no double when disabled", double_o, 1'b0);
`endif
        checkc("double cnt", cnt_o, 2'd1);
        for (int i = 0; i < 5; i++) cyc(1, 1);
        cyc(0, 0);
        check1("second release no long", long_o, 1'b0);
        settle();

        // Second press coincident with gap expiry.
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 1); cyc(0, 1);
        cyc(1, 1);
`ifdef PRESS_CLASSIFIER_DOUBLE_PRESS_EN
        check1("tie double", double_o, 1'b1);
        check1("tie double no short", short_o, 1'b0);
`endif
        cyc(0, 0);
        settle();

        // Reset while in the long-held state, with db held high through release.
        cyc(1, 0);
        cyc(1, 1); cyc(1, 1); cyc(1, 1); cyc(1, 1);
        cyc(1, 0);
        rst = 1'b1;
        cyc(1, 0);
        check1("rst rise", rise_o, 1'b0);
        check1("rst fall", fall_o, 1'b0);
        check1("rst short", short_o, 1'b0);
        check1("rst long", long_o, 1'b0);
        check1("rst double", double_o, 1'b0);
        check1("rst busy", busy_o, 1'b0);
        checkc("rst cnt", cnt_o, 2'd0);
        rst = 1'b0;
        cyc(1, 0);
        check1("post-rst rise", rise_o, 1'b1);
        checkc("post-rst cnt", cnt_o, 2'd1);
        cyc(0, 0);
        settle();

        // Counter wrap: five presses on a 2-bit counter.
        rst = 1'b1;
        cyc(0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0);
            cyc(0, 0);
            settle();
        end
        checkc("wrap cnt", cnt_o, 2'd1);

        cyc(0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/press_classifier.md
# press_classifier

Downstream consumer of the debounced switch level. Samples the clean `db` signal, detects rising and falling edges, and times each press in `m_tick` units. Classifies every press as short, long or (optionally) double, and emits one-cycle event pulses plus a running press count for the control/display logic.

## Interface
- `LONG_TICKS`, default 20: number of `m_tick` pulses while held at which a press becomes long; legal range ≥ 1.
- `GAP_TICKS`, default 8: maximum `m_tick` pulses between a release and a second press for a double press; legal range ≥ 1.
- `PRESS_CNT_W`, default 16: width of the press counter.
- `clk_i`, input, 1: the single clock.
- `rst_i`, input, 1: synchronous, active-high reset.
- `db_i`, input, 1: debounced switch level; already synchronous to `clk_i`.
- `m_tick_i`, input, 1: one-cycle timebase pulse, the same tick that drives the debouncer.
- `rise_o`, output, 1: one-cycle pulse on a 0→1 transition of `db_i`.
- `fall_o`, output, 1: one-cycle pulse on a 1→0 transition of `db_i`.
- `short_press_o`, output, 1: one-cycle pulse when a press classifies as short.
- `long_press_o`, output, 1: one-cycle pulse when the hold time reaches `LONG_TICKS`.
- `double_press_o`, output, 1: one-cycle pulse on the second press of a double press.
- `busy_o`, output, 1: high whenever the FSM is not in IDLE.
- `press_cnt_o`, output, `PRESS_CNT_W`: total number of rising edges since reset.

## Operation
- `db_q` is a register of `db_i`.
- rise = `db_i & ~db_q`; fall = `~db_i & db_q`.
- `dur_cnt` counts `m_tick_i` while in PRESSED. It clears on rise. Its width holds `LONG_TICKS`.
- `gap_cnt` counts `m_tick_i` while in WAIT_GAP. It clears on entry to WAIT_GAP.
- `press_cnt_o` increments on every rise and wraps modulo 2^`PRESS_CNT_W`. It is independent of the FSM.

FSM states and transitions:
- **IDLE**
  - rise → PRESSED.
- **PRESSED**
  - fall, with `DOUBLE_PRESS_EN` defined → WAIT_GAP.
  - fall, without `DOUBLE_PRESS_EN` → IDLE and pulse `short_press_o`.
  - `m_tick_i` while `dur_cnt == LONG_TICKS-1` → LONG_HELD and pulse `long_press_o`.
  - If fall and the threshold tick occur in the same cycle, fall wins and the press is short.
- **LONG_HELD**
  - fall → IDLE. No further classification pulse.
- **WAIT_GAP**
  - rise → SECOND_HELD and pulse `double_press_o`. No `short_press_o` for the first press.
  - `m_tick_i` while `gap_cnt == GAP_TICKS-1` → IDLE and pulse `short_press_o`.
  - If rise and expiry occur in the same cycle, rise wins and the press is double.
- **SECOND_HELD**
  - fall → IDLE. Hold time is not classified, so a long second press is not reported.

General rules:
- Classification pulses are mutually exclusive in any cycle.
- At most one classification pulse occurs per press sequence.
- `rise_o` and `fall_o` are unaffected by the FSM state.

## Timing
- All outputs are registered.
- Latency: an event sampled at rising edge k produces its pulse during the cycle after edge k, high for exactly one cycle. Events are the `db_i` transition, or the `m_tick_i` that completes a count.
- `busy_o` and `press_cnt_o` update on the same edge as the transition that changes them.
- Reset (any cycle, including mid-press), on the next `clk_i` edge with `rst_i` high:
  - FSM goes to IDLE.
  - `db_q`, `dur_cnt`, `gap_cnt` and `press_cnt_o` go to 0.
  - All pulse outputs and `busy_o` go to 0.
- Because `db_q` resets to 0, a `db_i` held high through reset release is reported as a rise and a new press.
- `m_tick_i` is honoured only in PRESSED and WAIT_GAP and is ignored elsewhere.

## Configuration
- `PRESS_CLASSIFIER_DOUBLE_PRESS_EN` defined:
  - WAIT_GAP and SECOND_HELD are present.
  - `short_press_o` is delayed until the gap expires.
  - `double_press_o` is live.
- Undefined:
  - WAIT_GAP, SECOND_HELD and `gap_cnt` are compiled out.
  - `short_press_o` fires on release.
  - `double_press_o` is tied to 0.
  - `GAP_TICKS` is unused.

## Structure
- Shared package `press_fsm_pkg` holds:
  - `press_state_e` (IDLE, PRESSED, LONG_HELD, WAIT_GAP, SECOND_HELD), plus an invalid value used as the next-state default;
  - parameter legality checks, as constant functions.
- Sub-module `edge_detect`: the registered `db_q` plus the one-cycle rise and fall pulse generator. It is reusable on other debounced inputs.

## Test plan
- Short press, `LONG_TICKS`=4, `DOUBLE_PRESS_EN` off: high for 2 ticks then release → `rise_o` and `fall_o` pulse, one `short_press_o` the cycle after the fall, `press_cnt_o`=1.
- Long press: held for 6 ticks → `long_press_o` one cycle after the 4th tick, no `short_press_o` at release, `busy_o` low after release.
- Double press, `GAP_TICKS`=3, enabled: press, release, press again after 1 tick → `double_press_o` one cycle after the second rise, no `short_press_o`, `press_cnt_o`=2.
- Gap expiry: press, release, no press for 3 ticks → `short_press_o` one cycle after the 3rd tick.
- Tie cases:
  - fall coincident with the 4th tick → `short_press_o`, never `long_press_o`;
  - rise coincident with gap expiry → `double_press_o`.
- Reset mid-press, then wrap:
  - `rst_i` asserted in LONG_HELD → all outputs 0 next cycle;
  - with `PRESS_CNT_W`=2, 5 presses → `press_cnt_o`=1.
